// File: rtl/fwd_pipe_chain.sv
// DEPTH-stage write-back tracker: carries tag/dest/result toward the register file and
// answers youngest-first forwarding lookups. Optional counters behind FWD_PIPE_PERF_EN.
module fwd_pipe_chain #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int NSRC     = 2,
    parameter int LD_STAGE = 1,
    parameter int SW       = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               flush,
    input  logic               in_valid,
    input  logic               in_wr,
    input  logic [AW-1:0]      in_rd,
    input  logic [DW-1:0]      in_data,
    input  logic               in_rdy,
    input  logic [DW-1:0]      ld_data,
    input  logic [NSRC*AW-1:0] src_addr,
    output logic [NSRC*SW-1:0] fwd_sel,
    output logic [NSRC*DW-1:0] fwd_data,
    output logic               stall_req,
    output logic               wb_en,
    output logic [AW-1:0]      wb_addr,
    output logic [DW-1:0]      wb_data
`ifdef FWD_PIPE_PERF_EN
    ,
    output logic [31:0]        perf_fwd,
    output logic [31:0]        perf_stall
`endif
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] wr_q;
    logic [DEPTH-1:0] rdy_q;
    logic [AW-1:0]    rd_q   [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [DW-1:0]    eff    [DEPTH];
    logic             hit_found;
    logic [AW-1:0]    cur_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            wr_q  <= '0;
            rdy_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k]   <= '0;
                data_q[k] <= '0;
            end
        end else if (!hold) begin
            v_q[0]    <= in_valid & ~flush;
            wr_q[0]   <= in_wr;
            rd_q[0]   <= in_rd;
            data_q[0] <= in_data;
            rdy_q[0]  <= in_rdy;
            for (int k = 1; k < DEPTH; k++) begin
                v_q[k]  <= v_q[k-1];
                wr_q[k] <= wr_q[k-1];
                rd_q[k] <= rd_q[k-1];
                // A pending load leaving LD_STAGE picks up the memory data on its way out.
                if ((k - 1 == LD_STAGE) && !rdy_q[k-1]) begin
                    data_q[k] <= ld_data;
                    rdy_q[k]  <= 1'b1;
                end else begin
                    data_q[k] <= data_q[k-1];
                    rdy_q[k]  <= rdy_q[k-1];
                end
            end
        end else if (flush) begin
            v_q[0] <= 1'b0;
        end
    end

    always_comb begin
        ready = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ready[k] = rdy_q[k] | (k == LD_STAGE);
            eff[k]   = ((k == LD_STAGE) && !rdy_q[k]) ? ld_data : data_q[k];
        end
    end

    // Youngest hit decides: a not-ready younger hit stalls even if an older one is ready.
    always_comb begin
        fwd_sel   = '0;
        fwd_data  = '0;
        stall_req = 1'b0;
        hit_found = 1'b0;
        cur_src   = '0;
        for (int p = 0; p < NSRC; p++) begin
            cur_src   = src_addr[p*AW +: AW];
            hit_found = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!hit_found && v_q[k] && wr_q[k] && (rd_q[k] == cur_src) && (cur_src != '0)) begin
                    hit_found = 1'b1;
                    if (ready[k]) begin
                        fwd_sel[p*SW +: SW]  = SW'(k + 1);
                        fwd_data[p*DW +: DW] = eff[k];
                    end else begin
                        stall_req = 1'b1;
                    end
                end
            end
        end
    end

    assign wb_en   = v_q[DEPTH-1] & wr_q[DEPTH-1] & (rd_q[DEPTH-1] != '0);
    assign wb_addr = rd_q[DEPTH-1];
    assign wb_data = data_q[DEPTH-1];

`ifdef FWD_PIPE_PERF_EN
    logic [32:0] fwd_sum;

    always_comb begin
        fwd_sum = {1'b0, perf_fwd};
        for (int p = 0; p < NSRC; p++) begin
            if (fwd_sel[p*SW +: SW] != '0) begin
                fwd_sum = fwd_sum + 33'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fwd   <= '0;
            perf_stall <= '0;
        end else begin
            perf_fwd <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
            if (stall_req && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_pipe_chain.sv
// Directed bench for fwd_pipe_chain at DEPTH=3, LD_STAGE=1, NSRC=2; perf checks
// are compiled in only when FWD_PIPE_PERF_EN is defined.
module tb_fwd_pipe_chain;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 3;
    localparam int NSRC = 2;
    localparam int LD_STAGE = 1;
    localparam int SW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               hold;
    logic               flush;
    logic               in_valid;
    logic               in_wr;
    logic [AW-1:0]      in_rd;
    logic [DW-1:0]      in_data;
    logic               in_rdy;
    logic [DW-1:0]      ld_data;
    logic [NSRC*AW-1:0] src_addr;
    logic [NSRC*SW-1:0] fwd_sel;
    logic [NSRC*DW-1:0] fwd_data;
    logic               stall_req;
    logic               wb_en;
    logic [AW-1:0]      wb_addr;
    logic [DW-1:0]      wb_data;
`ifdef FWD_PIPE_PERF_EN
    logic [31:0]        perf_fwd;
    logic [31:0]        perf_stall;
`endif

    int checks = 0;
    int failures = 0;

    fwd_pipe_chain #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .NSRC(NSRC), .LD_STAGE(LD_STAGE)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_wr(in_wr), .in_rd(in_rd), .in_data(in_data),
        .in_rdy(in_rdy), .ld_data(ld_data), .src_addr(src_addr),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stall_req(stall_req),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef FWD_PIPE_PERF_EN
        , .perf_fwd(perf_fwd), .perf_stall(perf_stall)
`endif
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // drivers: inputs change 2 time units after the rising edge; outputs are sampled 1 unit later
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_entry(input logic wr, input logic [AW-1:0] rd,
                               input logic [DW-1:0] data, input logic rdy);
        in_valid = 1'b1;
        in_wr    = wr;
        in_rd    = rd;
        in_data  = data;
        in_rdy   = rdy;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        in_wr    = 1'b0;
        in_rd    = '0;
        in_data  = '0;
        in_rdy   = 1'b0;
    endtask

    task automatic set_src(input logic [AW-1:0] s0, input logic [AW-1:0] s1);
        src_addr = {s1, s0};
    endtask

    function automatic logic [SW-1:0] sel_of(input int p);
        return fwd_sel[p*SW +: SW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int p);
        return fwd_data[p*DW +: DW];
    endfunction

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0; ld_data = '0;
        drive_entry(1'b1, 5'd4, 32'h4444, 1'b1);
        set_src(5'd4, 5'd4);

        // reset held 2 cycles with in_valid high
        step();
        step();
        rst = 1'b0;
        drive_idle();
        settle();
        check("rst_wb_en", 64'(wb_en), 64'd0);
        check("rst_wb_addr", 64'(wb_addr), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_sel", 64'(fwd_sel), 64'd0);
        check("rst_fwd_data", 64'(fwd_data), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);

        // ALU forward of r5
        drive_entry(1'b1, 5'd5, 32'h0000_1234, 1'b1);
        set_src(5'd5, 5'd0);
        step(); drive_idle(); settle();
        check("alu_sel_c1", 64'(sel_of(0)), 64'd1);
        check("alu_data_c1", 64'(data_of(0)), 64'h1234);
        check("alu_p1_none", 64'(sel_of(1)), 64'd0);
        step(); settle();
        check("alu_sel_c2", 64'(sel_of(0)), 64'd2);
        check("alu_data_c2", 64'(data_of(0)), 64'h1234);
        step(); settle();
        check("alu_sel_c3", 64'(sel_of(0)), 64'd3);
        check("alu_data_c3", 64'(data_of(0)), 64'h1234);
        check("alu_wb_en", 64'(wb_en), 64'd1);
        check("alu_wb_addr", 64'(wb_addr), 64'd5);
        check("alu_wb_data", 64'(wb_data), 64'h1234);
        step(); settle();
        check("alu_sel_c4", 64'(sel_of(0)), 64'd0);
        check("alu_wb_en_c4", 64'(wb_en), 64'd0);

        // load-use on r7
        drive_entry(1'b1, 5'd7, 32'hDEAD_0000, 1'b0);
        set_src(5'd7, 5'd0);
        step(); drive_idle(); settle();
        check("ld_stall_c1", 64'(stall_req), 64'd1);
        check("ld_sel_c1", 64'(sel_of(0)), 64'd0);
        check("ld_data_c1", 64'(data_of(0)), 64'd0);
        step(); ld_data = 32'h0000_BEEF; settle();
        check("ld_stall_c2", 64'(stall_req), 64'd0);
        check("ld_sel_c2", 64'(sel_of(0)), 64'd2);
        check("ld_data_c2", 64'(data_of(0)), 64'hBEEF);
        step(); ld_data = 32'h5555_5555; settle();
        check("ld_sel_c3", 64'(sel_of(0)), 64'd3);
        check("ld_data_c3", 64'(data_of(0)), 64'hBEEF);
        check("ld_wb_data", 64'(wb_data), 64'hBEEF);
        check("ld_wb_en", 64'(wb_en), 64'd1);
        step(); ld_data = '0;

        // youngest r3 wins on port 1
        drive_entry(1'b1, 5'd3, 32'h11, 1'b1);
        set_src(5'd0, 5'd3);
        step(); drive_entry(1'b1, 5'd3, 32'h22, 1'b1);
        step(); drive_idle(); settle();
        check("prio_sel_c1", 64'(sel_of(1)), 64'd1);
        check("prio_data_c1", 64'(data_of(1)), 64'h22);
        check("prio_p0_none", 64'(sel_of(0)), 64'd0);
        step(); settle();
        check("prio_sel_c2", 64'(sel_of(1)), 64'd2);
        check("prio_data_c2", 64'(data_of(1)), 64'h22);
        step(); step();

        // writes to r0 never hit and never write back
        drive_entry(1'b1, 5'd0, 32'h99, 1'b1);
        set_src(5'd0, 5'd0);
        step(); drive_idle(); settle();
        check("r0_sel", 64'(fwd_sel), 64'd0);
        step(); step(); settle();
        check("r0_wb_en", 64'(wb_en), 64'd0);
        step();

        // younger not-ready r6 blocks older ready r6
        drive_entry(1'b1, 5'd6, 32'h66, 1'b1);
        set_src(5'd6, 5'd0);
        step(); drive_entry(1'b1, 5'd6, 32'h0, 1'b0);
        step(); drive_idle(); settle();
        check("young_ld_stall", 64'(stall_req), 64'd1);
        check("young_ld_sel", 64'(sel_of(0)), 64'd0);
        step(); step(); step();

        // store (in_wr=0, in_rdy=0) never hits
        drive_entry(1'b0, 5'd8, 32'h0, 1'b0);
        set_src(5'd8, 5'd8);
        step(); drive_idle(); settle();
        check("store_stall", 64'(stall_req), 64'd0);
        check("store_sel", 64'(fwd_sel), 64'd0);
        step(); step(); step();

        // hold keeps r9 in stage 0
        drive_entry(1'b1, 5'd9, 32'h9, 1'b1);
        set_src(5'd9, 5'd0);
        step(); drive_idle(); hold = 1'b1; settle();
        check("hold_sel_c1", 64'(sel_of(0)), 64'd1);
        step(); settle();
        check("hold_sel_c2", 64'(sel_of(0)), 64'd1);
        check("hold_data_c2", 64'(data_of(0)), 64'h9);
        step(); hold = 1'b0; settle();
        check("hold_sel_c3", 64'(sel_of(0)), 64'd1);
        step(); settle();
        check("hold_release", 64'(sel_of(0)), 64'd2);

        // flush an r10 entry while r9 moves to write-back
        drive_entry(1'b1, 5'd10, 32'hA, 1'b1);
        flush = 1'b1;
        set_src(5'd10, 5'd0);
        step(); flush = 1'b0; drive_idle(); settle();
        check("flush_sel", 64'(sel_of(0)), 64'd0);
        check("r9_wb_en", 64'(wb_en), 64'd1);
        check("r9_wb_addr", 64'(wb_addr), 64'd9);
        step(); step(); settle();
        check("flush_wb_en", 64'(wb_en), 64'd0);

        // hold together with flush clears stage 0 in place
        drive_entry(1'b1, 5'd12, 32'hC, 1'b1);
        set_src(5'd12, 5'd0);
        step(); drive_idle(); settle();
        check("hf_sel_before", 64'(sel_of(0)), 64'd1);
        hold = 1'b1; flush = 1'b1;
        step(); hold = 1'b0; flush = 1'b0; settle();
        check("hf_sel_after", 64'(sel_of(0)), 64'd0);
        step(); step(); settle();
        check("hf_wb_en", 64'(wb_en), 64'd0);

        // reset mid-operation discards entries
        drive_entry(1'b1, 5'd13, 32'hD, 1'b1);
        set_src(5'd13, 5'd0);
        step(); drive_idle(); settle();
        check("mid_sel_pre", 64'(sel_of(0)), 64'd1);
        rst = 1'b1;
        step(); rst = 1'b0; settle();
        check("mid_rst_sel", 64'(fwd_sel), 64'd0);
        check("mid_rst_wb", 64'(wb_en), 64'd0);

`ifdef FWD_PIPE_PERF_EN
        check("perf_fwd_rst", 64'(perf_fwd), 64'd0);
        check("perf_stall_rst", 64'(perf_stall), 64'd0);
        drive_entry(1'b1, 5'd5, 32'h1234, 1'b1);
        set_src(5'd5, 5'd5);
        step(); drive_idle();
        step(); step(); step(); settle();
        check("perf_fwd_6", 64'(perf_fwd), 64'd6);
        check("perf_stall_0", 64'(perf_stall), 64'd0);
        drive_entry(1'b1, 5'd7, 32'h0, 1'b0);
        set_src(5'd7, 5'd0);
        step(); drive_idle();
        step(); ld_data = 32'hBEEF;
        step(); step(); settle();
        check("perf_stall_1", 64'(perf_stall), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
